// File: rtl/frame_clear_arbiter.sv
// frame_clear_arbiter
// Arbitrates the frame buffer and z-buffer write ports between the rasterizer
// and a full-buffer clear engine. A clear request waits for vertical blanking.
// It then writes every address once, in ascending order, with the fill values.
// While a clear runs, the rasterizer is stalled. Requests that arrive while a
// clear is waiting or running collapse into a single follow-up clear.
module frame_clear_arbiter #(
    parameter int         FB_DEPTH    = 76800,
    parameter int         ADDR_W      = 17,
    parameter logic [3:0] CLEAR_COLOR = 4'h0,
    parameter logic [7:0] Z_CLEAR     = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              vblank,
    input  logic              rast_fb_we,
    input  logic              rast_zb_we,
    input  logic [ADDR_W-1:0] rast_addr,
    input  logic [3:0]        rast_fb_data,
    input  logic [7:0]        rast_zb_data,
    output logic              rast_stall,
    output logic              fb_we,
    output logic              zb_we,
    output logic [ADDR_W-1:0] fb_wraddress,
    output logic [ADDR_W-1:0] zb_wraddress,
    output logic [3:0]        fb_data,
    output logic [7:0]        zb_data,
    output logic              clear_busy,
    output logic              clear_done
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_VBLANK = 2'd1,
        ST_CLEAR       = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                pending_q, pending_d;

    logic                fb_we_q, fb_we_d;
    logic                zb_we_q, zb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [ADDR_W-1:0]   zb_addr_q, zb_addr_d;
    logic [3:0]          fb_data_q, fb_data_d;
    logic [7:0]          zb_data_q, zb_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state, clear counter, pending-request and write-port mux selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;

        // Default: the rasterizer owns the memory ports
        fb_we_d   = rast_fb_we;
        zb_we_d   = rast_zb_we;
        fb_addr_d = rast_addr;
        zb_addr_d = rast_addr;
        fb_data_d = rast_fb_data;
        zb_data_d = rast_zb_data;
        done_d    = 1'b0;
        // Busy is registered to line up with the registered write stream, so
        // it stays high through the final clear write and drops one cycle later
        busy_d    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                // Any raster write on this same cycle is still passed through
                if (clear_req) begin
                    state_d = ST_WAIT_VBLANK;
                end
            end

            ST_WAIT_VBLANK: begin
                if (clear_req) begin
                    pending_d = 1'b1;
                end
                if (vblank) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end

            ST_CLEAR: begin
                fb_we_d   = 1'b1;
                zb_we_d   = 1'b1;
                fb_addr_d = cnt_q;
                zb_addr_d = cnt_q;
                fb_data_d = CLEAR_COLOR;
                zb_data_d = Z_CLEAR;
                if (cnt_q == LAST_ADDR) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    // A request seen on this last cycle also counts as pending
                    if (pending_q || clear_req) begin
                        pending_d = 1'b0;
                        state_d   = ST_WAIT_VBLANK;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    // vblank is deliberately ignored here: a clear never pauses
                    cnt_d = cnt_q + 1'b1;
                    if (clear_req) begin
                        pending_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered memory-side outputs; reset aborts any clear in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            fb_we_q   <= 1'b0;
            zb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            zb_addr_q <= '0;
            fb_data_q <= '0;
            zb_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            fb_we_q   <= fb_we_d;
            zb_we_q   <= zb_we_d;
            fb_addr_q <= fb_addr_d;
            zb_addr_q <= zb_addr_d;
            fb_data_q <= fb_data_d;
            zb_data_q <= zb_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The stall comes straight from the state so the rasterizer holds its write
    // on the same cycle the clear owns the ports
    assign rast_stall   = (state_q == ST_CLEAR);

    assign fb_we        = fb_we_q;
    assign zb_we        = zb_we_q;
    assign fb_wraddress = fb_addr_q;
    assign zb_wraddress = zb_addr_q;
    assign fb_data      = fb_data_q;
    assign zb_data      = zb_data_q;
    assign clear_busy   = busy_q;
    assign clear_done   = done_q;

endmodule

// File: tb/tb_frame_clear_arbiter.sv
// Self-checking bench for frame_clear_arbiter with a small buffer (16 words).
// A behavioural model tracks "clearing / waiting / next address / one more
// clear wanted" and predicts the write port each cycle. Directed scenarios are
// followed by a randomized run.
module tb_frame_clear_arbiter;

    localparam int DEPTH = 16;
    localparam int AW    = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_req;
    logic          vblank;
    logic          rast_fb_we;
    logic          rast_zb_we;
    logic [AW-1:0] rast_addr;
    logic [3:0]    rast_fb_data;
    logic [7:0]    rast_zb_data;
    logic          rast_stall;
    logic          fb_we;
    logic          zb_we;
    logic [AW-1:0] fb_wraddress;
    logic [AW-1:0] zb_wraddress;
    logic [3:0]    fb_data;
    logic [7:0]    zb_data;
    logic          clear_busy;
    logic          clear_done;

    frame_clear_arbiter #(
        .FB_DEPTH    (DEPTH),
        .ADDR_W      (AW),
        .CLEAR_COLOR (4'h0),
        .Z_CLEAR     (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear_req    (clear_req),
        .vblank       (vblank),
        .rast_fb_we   (rast_fb_we),
        .rast_zb_we   (rast_zb_we),
        .rast_addr    (rast_addr),
        .rast_fb_data (rast_fb_data),
        .rast_zb_data (rast_zb_data),
        .rast_stall   (rast_stall),
        .fb_we        (fb_we),
        .zb_we        (zb_we),
        .fb_wraddress (fb_wraddress),
        .zb_wraddress (zb_wraddress),
        .fb_data      (fb_data),
        .zb_data      (zb_data),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the buffer should be doing, in plain terms
    bit clearing;      // a clear sweep is under way
    bit waiting;       // a clear has been asked for and waits on vblank
    bit again;         // one more clear wanted after the current one
    int next_addr;     // next address the sweep will write

    // Expected registered outputs after the coming edge
    int e_fb_we, e_zb_we, e_addr_fb, e_addr_zb, e_fbd, e_zbd, e_done, e_busy;

    // Observation counters used by directed scenarios
    int done_seen;
    int hold_seen;
    int hold_addr;
    int hold_data;

    task automatic model_reset();
        clearing  = 0;
        waiting   = 0;
        again     = 0;
        next_addr = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied
    task automatic model_edge();
        e_busy = (clearing || waiting) ? 1 : 0;
        if (clearing) begin
            e_fb_we   = 1;
            e_zb_we   = 1;
            e_addr_fb = next_addr;
            e_addr_zb = next_addr;
            e_fbd     = 0;
            e_zbd     = 'hFF;
            e_done    = (next_addr == DEPTH - 1) ? 1 : 0;
            if (clear_req) again = 1;
            if (next_addr == DEPTH - 1) begin
                clearing  = 0;
                next_addr = 0;
                if (again) begin
                    again   = 0;
                    waiting = 1;
                end
            end else begin
                next_addr = next_addr + 1;
            end
        end else begin
            e_fb_we   = int'(rast_fb_we);
            e_zb_we   = int'(rast_zb_we);
            e_addr_fb = int'(rast_addr);
            e_addr_zb = int'(rast_addr);
            e_fbd     = int'(rast_fb_data);
            e_zbd     = int'(rast_zb_data);
            e_done    = 0;
            if (waiting) begin
                if (clear_req) again = 1;
                if (vblank) begin
                    waiting   = 0;
                    clearing  = 1;
                    next_addr = 0;
                end
            end else if (clear_req) begin
                waiting = 1;
            end
        end
    endtask

    // One clock: predict, wait for the edge, then compare away from it
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("fb_we",        32'(fb_we),        32'(e_fb_we));
        check("zb_we",        32'(zb_we),        32'(e_zb_we));
        check("fb_wraddress", 32'(fb_wraddress), 32'(e_addr_fb));
        check("zb_wraddress", 32'(zb_wraddress), 32'(e_addr_zb));
        check("fb_data",      32'(fb_data),      32'(e_fbd));
        check("zb_data",      32'(zb_data),      32'(e_zbd));
        check("clear_done",   32'(clear_done),   32'(e_done));
        check("clear_busy",   32'(clear_busy),   32'(e_busy));
        check("rast_stall",   32'(rast_stall),   32'(clearing));
        if (clear_done) done_seen++;
        if (fb_we && (int'(fb_wraddress) == hold_addr) && (int'(fb_data) == hold_data))
            hold_seen++;
    endtask

    task automatic raster_idle();
        rast_fb_we   = 0;
        rast_zb_we   = 0;
        rast_addr    = '0;
        rast_fb_data = '0;
        rast_zb_data = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fb_we"},   32'(fb_we),        0);
        check({tag, "_zb_we"},   32'(zb_we),        0);
        check({tag, "_fb_addr"}, 32'(fb_wraddress), 0);
        check({tag, "_zb_addr"}, 32'(zb_wraddress), 0);
        check({tag, "_fb_data"}, 32'(fb_data),      0);
        check({tag, "_zb_data"}, 32'(zb_data),      0);
        check({tag, "_busy"},    32'(clear_busy),   0);
        check({tag, "_done"},    32'(clear_done),   0);
        check({tag, "_stall"},   32'(rast_stall),   0);
    endtask

    int stall_cycles;
    int guard;

    initial begin
        reset     = 0;
        clear_req = 0;
        vblank    = 0;
        raster_idle();
        model_reset();
        done_seen = 0;
        hold_seen = 0;
        hold_addr = -1;
        hold_data = -1;

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1;
        $display("[TB] reset released");

        // Pass-through in IDLE
        rast_fb_we = 1; rast_zb_we = 1; rast_addr = 5;
        rast_fb_data = 4'hA; rast_zb_data = 8'h3C;
        step();
        check("pt_fb_we", 32'(fb_we), 1);
        check("pt_zb_we", 32'(zb_we), 1);
        check("pt_addr",  32'(fb_wraddress), 5);
        check("pt_fbd",   32'(fb_data), 'hA);
        check("pt_zbd",   32'(zb_data), 'h3C);
        check("pt_stall", 32'(rast_stall), 0);
        raster_idle();
        step();
        $display("[TB] pass-through write addr 5");

        // Clear gated by vblank, then a full sweep
        clear_req = 1; vblank = 0;
        step();
        clear_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("gate_no_write", 32'(fb_we), 0);
        end
        vblank = 1;
        step();
        check("gate_no_write_yet", 32'(fb_we), 0);
        vblank = 0;
        done_seen = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check("sweep_we",   32'(fb_we & zb_we), 1);
            check("sweep_addr", 32'(fb_wraddress), 32'(i));
            check("sweep_fbd",  32'(fb_data), 0);
            check("sweep_zbd",  32'(zb_data), 'hFF);
            check("sweep_done", 32'(clear_done), (i == DEPTH - 1) ? 1 : 0);
            check("sweep_busy", 32'(clear_busy), 1);
        end
        step();
        check("sweep_busy_drop", 32'(clear_busy), 0);
        check("sweep_done_count", 32'(done_seen), 1);
        $display("[TB] clear sweep of %0d words", DEPTH);

        // Held raster write during a clear
        clear_req = 1; vblank = 1;
        step();
        clear_req = 0;
        step();
        vblank = 0;
        rast_fb_we = 1; rast_zb_we = 1; rast_addr = 9;
        rast_fb_data = 4'h7; rast_zb_data = 8'h5A;
        hold_addr = 9; hold_data = 7; hold_seen = 0;
        stall_cycles = (rast_stall) ? 1 : 0;
        guard = 0;
        while (rast_stall && guard < 40) begin
            step();
            if (rast_stall) stall_cycles++;
            guard++;
        end
        check("hold_stall_bound", 32'(guard < 40), 1);
        check("hold_stall_cycles", 32'(stall_cycles), 32'(DEPTH));
        check("hold_none_during", 32'(hold_seen), 0);
        step();
        check("hold_emitted_we",   32'(fb_we & zb_we), 1);
        check("hold_emitted_addr", 32'(fb_wraddress), 9);
        check("hold_emitted_zbd",  32'(zb_data), 'h5A);
        raster_idle();
        step();
        step();
        check("hold_once", 32'(hold_seen), 1);
        hold_addr = -1; hold_data = -1;
        $display("[TB] held raster write released once");

        // Three requests during one clear collapse into one follow-up
        done_seen = 0;
        clear_req = 1; vblank = 1;
        step();
        clear_req = 0;
        step();
        vblank = 0;
        for (int i = 0; i < DEPTH; i++) begin
            clear_req = (i == 2 || i == 5 || i == 9) ? 1 : 0;
            step();
        end
        clear_req = 0;
        for (int i = 0; i < 8; i++) step();
        check("merge_waiting_busy", 32'(clear_busy), 1);
        check("merge_first_only",   32'(done_seen), 1);
        vblank = 1;
        for (int i = 0; i < 24; i++) step();
        vblank = 0;
        for (int i = 0; i < 6; i++) step();
        check("merge_done_total", 32'(done_seen), 2);
        check("merge_idle", 32'(clear_busy), 0);
        $display("[TB] merged requests produced %0d clears", done_seen);

        // Reset in the middle of a clear
        clear_req = 1; vblank = 1;
        step();
        clear_req = 0;
        step();
        for (int i = 0; i < 7; i++) step();
        check("abort_at_cnt7", 32'(next_addr), 7);
        #2;
        reset = 0;
        #1;
        check_all_zero("abort");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_write", 32'(fb_we | zb_we), 0);
        end
        clear_req = 1;
        step();
        clear_req = 0;
        step();
        step();
        check("abort_restart_we",   32'(fb_we), 1);
        check("abort_restart_addr", 32'(fb_wraddress), 0);
        vblank = 0;
        for (int i = 0; i < DEPTH + 2; i++) step();
        $display("[TB] reset abort and restart from addr 0");

        // Request coincident with a raster write while vblank is high
        clear_req = 1; vblank = 1;
        rast_fb_we = 1; rast_zb_we = 1; rast_addr = 3;
        rast_fb_data = 4'hC; rast_zb_data = 8'h11;
        step();
        check("coinc_write_we",   32'(fb_we), 1);
        check("coinc_write_addr", 32'(fb_wraddress), 3);
        check("coinc_write_fbd",  32'(fb_data), 'hC);
        check("coinc_stall0",     32'(rast_stall), 0);
        clear_req = 0;
        raster_idle();
        step();
        check("coinc_clear_begins", 32'(rast_stall), 1);
        step();
        check("coinc_first_addr", 32'(fb_wraddress), 0);
        vblank = 0;
        for (int i = 0; i < DEPTH + 2; i++) step();
        $display("[TB] coincident request and raster write");

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            clear_req    = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) vblank = ~vblank;
            rast_fb_we   = $urandom_range(0, 1);
            rast_zb_we   = $urandom_range(0, 1);
            rast_addr    = AW'($urandom_range(0, 1023));
            rast_fb_data = 4'($urandom);
            rast_zb_data = 8'($urandom);
            step();
        end
        clear_req = 0;
        raster_idle();
        $display("[TB] random phase complete, %0d clears seen overall", done_seen);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
